ring_output_port: RTL

Parametrised ring-router output port. It generalises the two-source (ring plus PE), two-virtual-channel output stage to `NUM_SRC` sources with round-robin arbitration per virtual channel. A one-flit holding buffer sits on each VC, the hop field width and position are configurable, and refill can happen in the same cycle as drain. It sits between the router input buffers and one downstream ring link (cw or ccw), driving the link with the `so`/`ro` handshake and polarity-based even/odd VC time-multiplexing.

---
 rtl/ring_output_port.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ring_output_port.sv
// ring_output_port
// ----------------
// Output stage of a ring router. NUM_SRC requesters compete, per virtual
// channel, for a one-flit holding buffer using round-robin arbitration. The
// link is time-multiplexed between the even and odd VC by `polarity`: the
// selected VC drains its buffer onto the link when the downstream is ready.
// On the way out the hop field is shifted right by one position.
// A buffer may be drained and refilled at the same edge, which gives one flit
// per VC per matching-polarity cycle.
//
// Ports
//   clk         in   clock, all state on the rising edge
//   rst         in   synchronous active-high reset
//   polarity    in   0: even VC owns the link, 1: odd VC owns the link
//   req_even    in   [NUM_SRC]   per-source request, even VC
//   req_odd     in   [NUM_SRC]   per-source request, odd VC
//   data_even   in   [NUM_SRC*DATA_WIDTH] source i flit at [i*DATA_WIDTH +: DATA_WIDTH]
//   data_odd    in   [NUM_SRC*DATA_WIDTH] same layout, odd VC
//   grant_even  out  [NUM_SRC]   one-cycle one-hot capture pulse, even VC
//   grant_odd   out  [NUM_SRC]   one-cycle one-hot capture pulse, odd VC
//   so          out  flit on dout is valid this cycle
//   ro          in   downstream ready
//   dout        out  [DATA_WIDTH] outgoing flit ("do" is a reserved word)
//   vc_valid    out  [2] bit0 even buffer occupied, bit1 odd buffer occupied

// One virtual channel: round-robin arbiter plus a single-flit holding buffer.
module ring_output_port_vc #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_SRC    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          drain,
  input  logic [NUM_SRC-1:0]            req,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] data,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          valid,
  output logic [DATA_WIDTH-1:0]         flit
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
  logic [NUM_SRC-1:0]    elig;
  logic [NUM_SRC-1:0]    win_oh;
  logic [DATA_WIDTH-1:0] win_data;
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      ptr_nxt;
  logic [PTR_W-1:0]      idx;
  logic                  found;
  logic                  free;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_data[i] = data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // A source whose grant is visible this cycle is still presenting the flit
  // that was just captured, so it must not win again at this edge.
  assign elig = req & ~grant;
  assign free = ~valid | drain;

  // Round-robin pick: first eligible source starting at ptr, wrapping at NUM_SRC.
  always_comb begin
    win_oh   = '0;
    win_data = '0;
    ptr_nxt  = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_SRC);
      if (!found && elig[idx]) begin
        found       = 1'b1;
        win_oh[idx] = 1'b1;
        win_data    = src_data[idx];
        ptr_nxt     = PTR_W'((int'(ptr) + k + 1) % NUM_SRC);
      end
    end
  end

  // Buffer occupancy, captured flit, grant pulse and arbitration pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      flit  <= '0;
      ptr   <= '0;
      grant <= '0;
    end else begin
      grant <= '0;
      if (free && found) begin
        valid <= 1'b1;
        flit  <= win_data;
        grant <= win_oh;
        ptr   <= ptr_nxt;
      end else if (drain) begin
        valid <= 1'b0;
      end else begin
        valid <= valid;
      end
    end
  end

endmodule

module ring_output_port #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_SRC    = 2,
  parameter int HOP_LSB    = 48,
  parameter int HOP_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          polarity,
  input  logic [NUM_SRC-1:0]            req_even,
  input  logic [NUM_SRC-1:0]            req_odd,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] data_even,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] data_odd,
  output logic [NUM_SRC-1:0]            grant_even,
  output logic [NUM_SRC-1:0]            grant_odd,
  output logic                          so,
  input  logic                          ro,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [1:0]                    vc_valid
);

  logic                  valid_even;
  logic                  valid_odd;
  logic [DATA_WIDTH-1:0] flit_even;
  logic [DATA_WIDTH-1:0] flit_odd;
  logic                  drain_even;
  logic                  drain_odd;

  // Each hop consumes one position of the thermometer hop count.
  function automatic logic [DATA_WIDTH-1:0] hop_advance(input logic [DATA_WIDTH-1:0] f_in);
    logic [DATA_WIDTH-1:0] f;
    f = f_in;
    f[HOP_LSB +: HOP_WIDTH] = f_in[HOP_LSB +: HOP_WIDTH] >> 1;
    return f;
  endfunction

  // polarity selects exactly one VC, so at most one drain per edge.
  assign drain_even = valid_even & ro & ~polarity;
  assign drain_odd  = valid_odd  & ro &  polarity;

  ring_output_port_vc #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_SRC   (NUM_SRC)
  ) u_vc_even (
    .clk  (clk),
    .rst  (rst),
    .drain(drain_even),
    .req  (req_even),
    .data (data_even),
    .grant(grant_even),
    .valid(valid_even),
    .flit (flit_even)
  );

  ring_output_port_vc #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_SRC   (NUM_SRC)
  ) u_vc_odd (
    .clk  (clk),
    .rst  (rst),
    .drain(drain_odd),
    .req  (req_odd),
    .data (data_odd),
    .grant(grant_odd),
    .valid(valid_odd),
    .flit (flit_odd)
  );

  assign vc_valid = {valid_odd, valid_even};

  // Link register: dout keeps its last flit when nothing is sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      so   <= 1'b0;
      dout <= '0;
    end else begin
      so <= drain_even | drain_odd;
      if (drain_even) begin
        dout <= hop_advance(flit_even);
      end else if (drain_odd) begin
        dout <= hop_advance(flit_odd);
      end else begin
        dout <= dout;
      end
    end
  end

endmodule
